// File: rtl/tpu_weight_dma.sv
// tpu_weight_dma: copies the selected layer's weight block from the shared
// weight-store BRAM into the core-local weight buffer, starting at address 0.
// Optional feature macro: DMA_CHECKSUM_EN adds checksum_o, the 32-bit modulo
// sum of every word written during the current transfer.
//
// Handshake with the layer controller: start_dma_i is a single-cycle request.
// It is accepted only in IDLE; busy_o rises the cycle after acceptance.
// dma_done_o is a single-cycle completion pulse that coincides with the last
// busy_o cycle. A request while busy (including the done cycle) is dropped,
// not queued.
module tpu_weight_dma #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1,
    parameter int BASE0  = 0,
    parameter int BASE1  = 16,
    parameter int BASE2  = 80,
    parameter int BASE3  = 208,
    parameter int LEN0   = 16,
    parameter int LEN1   = 64,
    parameter int LEN2   = 128,
    parameter int LEN3   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_dma_i,
    input  logic [1:0]        nth_conv_i,
    output logic              dma_done_o,
    output logic              busy_o,
    output logic              src_en_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [DATA_W-1:0] src_rdata_i,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [DATA_W-1:0] dst_wdata_o,
`ifdef DMA_CHECKSUM_EN
    output logic [31:0]       checksum_o,
`endif
    output logic [1:0]        dbg_state_o
);

    // Counters carry one extra bit so a full 2^ADDR_W block length fits.
    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     len_q;
    logic [CW-1:0]     rd_cnt;     // reads issued so far; also offset of the next read
    logic [CW-1:0]     wr_cnt;     // writes issued so far; also the next dst address
    logic [ADDR_W-1:0] sel_base;
    logic [CW-1:0]     sel_len;
    logic              start_ok;

    // Read-valid pipeline: bit k is high when a read issued k+1 cycles ago
    // is in flight. The top bit marks the cycle whose src_rdata_i is valid.
    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT:0]   vld_chain;
    logic              wr_fire;

    assign start_ok    = (state == IDLE) && start_dma_i;
    assign vld_chain   = {vld_sr, src_en_o};
    assign wr_fire     = vld_chain[RD_LAT-1];
    assign dst_we_o    = vld_sr[RD_LAT-1];
    assign dbg_state_o = state;

    // Read data passes straight through in its valid cycle; zero otherwise.
    assign dst_wdata_o = dst_we_o ? src_rdata_i : '0;

    // Decode the per-layer base address and block length.
    always_comb begin
        sel_base = '0;
        sel_len  = '0;
        case (nth_conv_i)
            2'd0: begin sel_base = ADDR_W'(BASE0); sel_len = CW'(LEN0); end
            2'd1: begin sel_base = ADDR_W'(BASE1); sel_len = CW'(LEN1); end
            2'd2: begin sel_base = ADDR_W'(BASE2); sel_len = CW'(LEN2); end
            default: begin sel_base = ADDR_W'(BASE3); sel_len = CW'(LEN3); end
        endcase
    end

    // Control FSM: accepts a start, issues one read per cycle, waits for the
    // last write to land, then pulses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            rd_cnt     <= '0;
            src_en_o   <= 1'b0;
            src_addr_o <= '0;
            busy_o     <= 1'b0;
            dma_done_o <= 1'b0;
        end else begin
            dma_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_dma_i) begin
                        base_q <= sel_base;
                        len_q  <= sel_len;
                        busy_o <= 1'b1;
                        if (sel_len != '0) begin
                            state      <= READ;
                            src_en_o   <= 1'b1;
                            src_addr_o <= sel_base;
                            rd_cnt     <= CW'(1);
                        end else begin
                            state      <= DONE;
                            dma_done_o <= 1'b1;
                            rd_cnt     <= '0;
                        end
                    end
                end
                READ: begin
                    if (rd_cnt == len_q) begin
                        state      <= DRAIN;
                        src_en_o   <= 1'b0;
                        src_addr_o <= '0;
                    end else begin
                        src_addr_o <= base_q + rd_cnt[ADDR_W-1:0];
                        rd_cnt     <= rd_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (wr_cnt == len_q) begin
                        state      <= DONE;
                        dma_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Write side: shift read-valid along and register the destination address
    // so it lines up with the cycle the source data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr     <= '0;
            wr_cnt     <= '0;
            dst_addr_o <= '0;
        end else begin
            vld_sr <= vld_chain[RD_LAT-1:0];
            if (start_ok) begin
                wr_cnt     <= '0;
                dst_addr_o <= '0;
            end else if (wr_fire) begin
                dst_addr_o <= wr_cnt[ADDR_W-1:0];
                wr_cnt     <= wr_cnt + CW'(1);
            end else begin
                dst_addr_o <= '0;
            end
        end
    end

`ifdef DMA_CHECKSUM_EN
    // Running sum of written words; holds its final value after done until
    // the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_o <= '0;
        end else if (start_ok) begin
            checksum_o <= '0;
        end else if (dst_we_o) begin
            checksum_o <= checksum_o + 32'(dst_wdata_o);
        end
    end
`endif

endmodule

// File: tb/tb_tpu_weight_dma.sv
// tb_tpu_weight_dma: directed bench for tpu_weight_dma. Three instances share
// clock, reset and the start request: g=0 default, g=1 with LEN1=0, g=2 with
// RD_LAT=3. Source BRAM word at address a holds a+1.
module tb_tpu_weight_dma;

  localparam int LOGN = 1024;
  localparam int BASE_T[4] = '{0, 16, 80, 208};
  localparam int LEN_T[4]  = '{16, 64, 128, 32};

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_dma = 1'b0;
  logic [1:0] nth_conv = 2'd0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT instances ----------------
  logic [2:0]        done_v, busy_v, src_en_v, dst_we_v;
  logic [2:0][11:0]  src_addr_v, dst_addr_v;
  logic [2:0][31:0]  src_rdata_v, dst_wdata_v;
  logic [2:0][1:0]   state_v;
`ifdef DMA_CHECKSUM_EN
  logic [2:0][31:0]  cks_v;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tpu_weight_dma #(
      .DATA_W(32), .ADDR_W(12),
      .RD_LAT((g == 2) ? 3 : 1),
      .LEN1((g == 1) ? 0 : 64)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .start_dma_i(start_dma), .nth_conv_i(nth_conv),
      .dma_done_o(done_v[g]), .busy_o(busy_v[g]),
      .src_en_o(src_en_v[g]), .src_addr_o(src_addr_v[g]),
      .src_rdata_i(src_rdata_v[g]),
      .dst_we_o(dst_we_v[g]), .dst_addr_o(dst_addr_v[g]),
      .dst_wdata_o(dst_wdata_v[g]),
`ifdef DMA_CHECKSUM_EN
      .checksum_o(cks_v[g]),
`endif
      .dbg_state_o(state_v[g])
    );
  end

  // ---------------- source BRAM model ----------------
  logic [31:0] pipe [3][3];

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      pipe[g][0] <= src_en_v[g] ? (32'(src_addr_v[g]) + 32'd1) : 32'hdead_beef;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end

  always_comb begin
    src_rdata_v = '0;
    for (int g = 0; g < 3; g++)
      src_rdata_v[g] = (g == 2) ? pipe[g][2] : pipe[g][0];
  end

  // ---------------- event logs (sampled on falling edge) ----------------
  int n_rd[3] = '{0, 0, 0};
  int n_wr[3] = '{0, 0, 0};
  int n_done[3] = '{0, 0, 0};
  int n_busy[3] = '{0, 0, 0};
  int rd_addr_log[3][LOGN];
  int rd_cyc_log[3][LOGN];
  int wr_addr_log[3][LOGN];
  int wr_data_log[3][LOGN];
  int wr_cyc_log[3][LOGN];
  int done_cyc_log[3][LOGN];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (src_en_v[g]) begin
        rd_addr_log[g][n_rd[g] % LOGN] = int'(src_addr_v[g]);
        rd_cyc_log[g][n_rd[g] % LOGN]  = cyc;
        n_rd[g]++;
      end
      if (dst_we_v[g]) begin
        wr_addr_log[g][n_wr[g] % LOGN] = int'(dst_addr_v[g]);
        wr_data_log[g][n_wr[g] % LOGN] = int'(dst_wdata_v[g]);
        wr_cyc_log[g][n_wr[g] % LOGN]  = cyc;
        n_wr[g]++;
      end
      if (done_v[g]) begin
        done_cyc_log[g][n_done[g] % LOGN] = cyc;
        n_done[g]++;
      end
      if (busy_v[g]) n_busy[g]++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_err = 0;
  int s_rd[3], s_wr[3], s_done[3], s_busy[3];

  function automatic int len_of(input int g, input int layer);
    if (g == 1 && layer == 1) return 0;
    return LEN_T[layer];
  endfunction

  function automatic int rl_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic take_snap();
    for (int g = 0; g < 3; g++) begin
      s_rd[g] = n_rd[g]; s_wr[g] = n_wr[g];
      s_done[g] = n_done[g]; s_busy[g] = n_busy[g];
    end
  endtask

  task automatic check_counts(input int g, input string tag, input int rd, input int wr,
                              input int dn, input int bz);
    chk($sformatf("%s_g%0d_nrd", tag, g), n_rd[g] - s_rd[g], rd);
    chk($sformatf("%s_g%0d_nwr", tag, g), n_wr[g] - s_wr[g], wr);
    chk($sformatf("%s_g%0d_ndone", tag, g), n_done[g] - s_done[g], dn);
    chk($sformatf("%s_g%0d_nbusy", tag, g), n_busy[g] - s_busy[g], bz);
  endtask

  // Compares one transfer's reads, writes and done pulse against the model,
  // starting at the given log positions; t is the start edge number.
  task automatic check_xfer(input int g, input string tag, input int t, input int layer,
                            input int ri, input int wi, input int di, input bit do_cks);
    int len = len_of(g, layer);
    int rl = rl_of(g);
    int base = BASE_T[layer];
    logic [31:0] exp_q[$];
    logic [31:0] w;
    logic [31:0] sum = '0;
    for (int i = 0; i < len; i++) exp_q.push_back(32'((base + i) % 4096) + 32'd1);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_g%0d_rd_addr%0d", tag, g, i), rd_addr_log[g][(ri + i) % LOGN], (base + i) % 4096);
      chk($sformatf("%s_g%0d_rd_cyc%0d", tag, g, i), rd_cyc_log[g][(ri + i) % LOGN], t + i);
      w = exp_q.pop_front();
      sum = sum + w;
      chk($sformatf("%s_g%0d_wr_addr%0d", tag, g, i), wr_addr_log[g][(wi + i) % LOGN], i);
      chk($sformatf("%s_g%0d_wr_data%0d", tag, g, i), wr_data_log[g][(wi + i) % LOGN], w);
      chk($sformatf("%s_g%0d_wr_cyc%0d", tag, g, i), wr_cyc_log[g][(wi + i) % LOGN], t + rl + i);
    end
    chk($sformatf("%s_g%0d_done_cyc", tag, g), done_cyc_log[g][di % LOGN],
        (len == 0) ? t : t + len + rl);
`ifdef DMA_CHECKSUM_EN
    if (do_cks) chk($sformatf("%s_g%0d_checksum", tag, g), cks_v[g], sum);
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_g%0d_done", tag, g), done_v[g], 0);
      chk($sformatf("%s_g%0d_busy", tag, g), busy_v[g], 0);
      chk($sformatf("%s_g%0d_src_en", tag, g), src_en_v[g], 0);
      chk($sformatf("%s_g%0d_src_addr", tag, g), src_addr_v[g], 0);
      chk($sformatf("%s_g%0d_dst_we", tag, g), dst_we_v[g], 0);
      chk($sformatf("%s_g%0d_dst_addr", tag, g), dst_addr_v[g], 0);
      chk($sformatf("%s_g%0d_dst_wdata", tag, g), dst_wdata_v[g], 0);
      chk($sformatf("%s_g%0d_state", tag, g), state_v[g], 0);
`ifdef DMA_CHECKSUM_EN
      chk($sformatf("%s_g%0d_checksum", tag, g), cks_v[g], 0);
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [1:0] layer, output int t);
    @(negedge clk); #1;
    start_dma = 1'b1;
    nth_conv  = layer;
    t = cyc + 1;
    @(negedge clk); #1;
    start_dma = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy_v != 3'b000 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_idle_in_budget"}, busy_v == 3'b000, 1);
  endtask

  task automatic run_layer(input string tag, input int layer);
    int t;
    take_snap();
    do_start(2'(layer), t);
    wait_idle(tag, 600);
    for (int g = 0; g < 3; g++) begin
      int len = len_of(g, layer);
      check_counts(g, tag, len, len, 1, (len == 0) ? 1 : len + rl_of(g) + 1);
      check_xfer(g, tag, t, layer, s_rd[g], s_wr[g], s_done[g], 1'b1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, t1, k;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Layer 0: 16 words, data 1..16, done 18 cycles after the start edge.
    run_layer("l0", 0);
    // Layer 2: reads 80..207 back to back, busy 130 cycles on g0.
    run_layer("l2", 2);

    // Second request mid-transfer is dropped; transfer finishes as layer 0.
    take_snap();
    do_start(2'd0, t);
    repeat (4) begin @(negedge clk); #1; end
    start_dma = 1'b1; nth_conv = 2'd1;
    @(negedge clk); #1;
    start_dma = 1'b0;
    wait_idle("mid", 600);
    for (int g = 0; g < 3; g++) begin
      check_counts(g, "mid", 16, 16, 1, 16 + rl_of(g) + 1);
      check_xfer(g, "mid", t, 0, s_rd[g], s_wr[g], s_done[g], 1'b1);
    end

    // Start in the done cycle is dropped; start one cycle later is taken.
    take_snap();
    do_start(2'd0, t);
    repeat (17) begin @(negedge clk); #1; end
    start_dma = 1'b1; nth_conv = 2'd2;
    @(negedge clk); #1;
    nth_conv = 2'd3;
    t1 = cyc + 1;
    @(negedge clk); #1;
    start_dma = 1'b0;
    wait_idle("back2back", 600);
    for (int g = 0; g < 2; g++) begin
      check_counts(g, "b2b", 48, 48, 2, 18 + 34);
      check_xfer(g, "b2b_l0", t, 0, s_rd[g], s_wr[g], s_done[g], 1'b0);
      check_xfer(g, "b2b_l3", t1, 3, s_rd[g] + 16, s_wr[g] + 16, s_done[g] + 1, 1'b1);
    end
    check_counts(2, "b2b", 16, 16, 1, 20);
    check_xfer(2, "b2b_l0", t, 0, s_rd[2], s_wr[2], s_done[2], 1'b1);

    // Layer 1: zero-length on g1 (done at T+1, no traffic), 64 words elsewhere.
    run_layer("l1", 1);
    // Layer 3: g2 shows RD_LAT=3 timing, first write T+4, done T+36.
    run_layer("l3", 3);

    // Abort with reset at the 10th write of layer 2.
    take_snap();
    do_start(2'd2, t);
    k = 0;
    while (n_wr[0] - s_wr[0] < 10 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk("abort_reached_wr10", n_wr[0] - s_wr[0], 10);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("abort_g%0d_no_done", g), n_done[g] - s_done[g], 0);
    chk("abort_g0_wr_stop", n_wr[0] - s_wr[0], 10);
    chk("abort_g1_wr_stop", n_wr[1] - s_wr[1], 10);
    chk("abort_idle", busy_v, 0);

    // Fresh layer-0 request after the abort completes normally.
    run_layer("post_abort", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tpu_weight_dma.md
# tpu_weight_dma

BRAM-to-BRAM copy engine answering the layer controller's DMA handshake. On a `start_dma_i` pulse it reads the selected layer's weight block from the shared weight-store BRAM and writes it, starting at address 0, into the core-local weight buffer. When the last word is written it returns a one-cycle `dma_done_i` pulse to the layer controller. It sits between `tpu_layer_ctrl` and the weight buffers of the conv/FC cores.

## Interface
Parameters:
- `DATA_W`, 32, word width of source and destination BRAM
- `ADDR_W`, 12, address width of source and destination BRAM
- `RD_LAT`, 1, source BRAM read latency in cycles, 1..4
- `BASE0`/`BASE1`/`BASE2`/`BASE3`, 0/16/80/208, source base address of layer n
- `LEN0`/`LEN1`/`LEN2`/`LEN3`, 16/64/128/32, words to copy for layer n; 0 is legal

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `start_dma_i`  in  1  one-cycle request from the layer controller
- `nth_conv_i`  in  2  layer select, sampled with `start_dma_i`
- `dma_done_o`  out  1  one-cycle completion pulse to the layer controller
- `busy_o`  out  1  high from the accepted start until `dma_done_o` inclusive
- `src_en_o`  out  1  source BRAM read enable
- `src_addr_o`  out  ADDR_W  source read address
- `src_rdata_i`  in  DATA_W  source read data, valid RD_LAT cycles after `src_en_o`
- `dst_we_o`  out  1  destination write enable
- `dst_addr_o`  out  ADDR_W  destination write address
- `dst_wdata_o`  out  DATA_W  destination write data

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on `start_dma_i`, latch `base`/`len` selected by `nth_conv_i`; clear read and write counters. Go to READ if len>0, else DONE.
- READ: one read per cycle. `src_addr_o` = base + rd_cnt. After the read with rd_cnt = len-1, go to DRAIN.
- Read-valid tracking: an RD_LAT-deep shift register of `src_en_o`. When its output is high: `dst_we_o`=1, `dst_addr_o`=wr_cnt, `dst_wdata_o`=`src_rdata_i`, then wr_cnt increments. Outputs are registered from the shift register.
- DRAIN: wait until wr_cnt = len, then go to DONE.
- DONE: `dma_done_o`=1 for one cycle; next state IDLE.
- `start_dma_i` outside IDLE is ignored and is not queued.
- Address arithmetic is modulo 2^ADDR_W (base+rd_cnt wraps). Counters are ADDR_W+1 bits wide, so len = 2^ADDR_W is representable.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, shift register cleared.
- `rst_n` low mid-transfer aborts immediately. No `dma_done_o` is issued; a new start is required.
- Start sampled at edge T:
  - first `src_en_o` in cycle T+1;
  - last read in cycle T+len;
  - last write in cycle T+len+RD_LAT;
  - `dma_done_o` in cycle T+len+RD_LAT+1.
- len=0: `dma_done_o` in cycle T+1, with no reads and no writes.
- `busy_o` is high in cycles T+1 through the `dma_done_o` cycle.
- A start in the same cycle as `dma_done_o` is ignored. A start one cycle later is accepted.

## Configuration
- `DMA_CHECKSUM_EN` defined:
  - adds output `checksum_o` (32 bits), the modulo-2^32 sum of all words written in the current transfer, zero-extended or truncated to 32 bits;
  - cleared on accepted start and on reset;
  - stable and valid from the `dma_done_o` cycle until the next accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, start with nth_conv=0, RD_LAT=1, source word i = i+1 → 16 writes to dst 0..15 with data 1..16; `dma_done_o` exactly once, 18 cycles after the start edge; checksum 136.
- nth_conv=2 → reads at src 80..207 on consecutive cycles; 128 writes to dst 0..127; `busy_o` high for 130 cycles.
- Second `start_dma_i` mid-transfer with nth_conv=1 → ignored; transfer completes as layer 0 with a single done pulse.
- LEN1=0 override, start nth_conv=1 → `dma_done_o` at T+1; `src_en_o` and `dst_we_o` never assert.
- RD_LAT=3, nth_conv=3 → 32 writes; first write at T+4; done at T+36; data ordering preserved.
- `rst_n` asserted at write 10 of layer 2 → all outputs 0 at once; no done; a later layer-0 start completes normally.
